// File: rtl/pe_dot_acc.sv
// Pipelined signed dot-product PE: per-lane multiply, adder tree, multi-beat
// accumulator, then fixed-point shift with saturate/wrap into a valid/ready output.
module pe_dot_acc #(
  parameter int unsigned W     = 21,
  parameter int unsigned LANES = 4,
  parameter int unsigned ACC_W = 2*W + $clog2(LANES) + 4,
  parameter int unsigned OUT_W = 21,
  parameter int unsigned FRAC  = 0,
  parameter bit          SAT   = 1'b1
) (
  input  logic               CLK,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_first,
  input  logic               in_last,
  input  logic [LANES*W-1:0] A,
  input  logic [LANES*W-1:0] B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_ovf
);

  localparam int unsigned LG = $clog2(LANES);
  localparam int unsigned PW = 2*W;
  localparam int unsigned SW = PW + LG;

  // Level 0 holds the products, level l holds LANES>>l partial sums.
  logic signed [SW-1:0]    node_q [LG+1][LANES];
  logic signed [SW-1:0]    node_d [LG+1][LANES];
  logic [LG:0]             vld_q, vld_d, fst_q, fst_d, lst_q, lst_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] res_q, res_d;
  logic                    res_vld_q, res_vld_d;
  logic                    out_valid_q, out_valid_d;
  logic [OUT_W-1:0]        out_data_q, out_data_d;
  logic                    out_ovf_q, out_ovf_d;

  logic signed [PW-1:0]    prod_c [LANES];
  logic signed [ACC_W-1:0] acc_sum_c;
  logic signed [ACC_W-1:0] shr_c;
  logic [OUT_W-1:0]        sat_c;
  logic                    fits_c;
  logic                    stall_c;

  for (genvar k = 0; k < LANES; k++) begin : g_mul
    assign prod_c[k] = PW'($signed(A[(LANES-k)*W-1 -: W])) *
                       PW'($signed(B[(LANES-k)*W-1 -: W]));
  end

  assign in_ready  = !stall_c;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

  // Next-state: the whole pipe, accumulator included, freezes on stall.
  always_comb begin
    stall_c     = out_valid_q && !out_ready;
    node_d      = node_q;
    vld_d       = vld_q;
    fst_d       = fst_q;
    lst_d       = lst_q;
    acc_d       = acc_q;
    res_d       = res_q;
    res_vld_d   = res_vld_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;

    acc_sum_c = (fst_q[LG] ? '0 : acc_q) + ACC_W'(node_q[LG][0]);
    shr_c     = res_q >>> FRAC;
    fits_c    = (ACC_W'($signed(shr_c[OUT_W-1:0])) == shr_c);
    sat_c     = shr_c[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};

    if (!stall_c) begin
      vld_d = {vld_q[LG-1:0], in_valid};
      fst_d = {fst_q[LG-1:0], in_first};
      lst_d = {lst_q[LG-1:0], in_last};
      for (int unsigned k = 0; k < LANES; k++) begin
        node_d[0][k] = SW'(prod_c[k]);
      end
      for (int unsigned l = 1; l <= LG; l++) begin
        for (int unsigned n = 0; n < LANES/2; n++) begin
          if (n < (LANES >> l)) begin
            node_d[l][n] = node_q[l-1][2*n] + node_q[l-1][2*n+1];
          end
        end
      end

      // An idle accumulator is zero, so a beat without first starts fresh.
      res_vld_d = vld_q[LG] && lst_q[LG];
      if (vld_q[LG]) begin
        acc_d = lst_q[LG] ? '0 : acc_sum_c;
        res_d = acc_sum_c;
      end

      if (res_vld_q) begin
        out_valid_d = 1'b1;
        out_data_d  = (SAT && !fits_c) ? sat_c : shr_c[OUT_W-1:0];
        out_ovf_d   = !fits_c;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned l = 0; l <= LG; l++) begin
        for (int unsigned n = 0; n < LANES; n++) begin
          node_q[l][n] <= '0;
        end
      end
      vld_q       <= '0;
      fst_q       <= '0;
      lst_q       <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      res_vld_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      node_q      <= node_d;
      vld_q       <= vld_d;
      fst_q       <= fst_d;
      lst_q       <= lst_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      res_vld_q   <= res_vld_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_pe_dot_acc.sv
// Bench for pe_dot_acc: three configurations (saturate, wrap, FRAC=4) in lockstep
// against a sequence-level dot-product scoreboard plus directed corner cases.
`timescale 1ns/1ps
module tb_pe_dot_acc;

  localparam int unsigned W     = 21;
  localparam int unsigned LANES = 4;
  localparam int unsigned OUT_W = 21;
  localparam int unsigned ACC_W = 2*W + 2 + 4;
  localparam int unsigned LW    = LANES*W;
  localparam longint      OMAX  = (longint'(1) <<< (OUT_W-1)) - 1;
  localparam longint      OMIN  = -(longint'(1) <<< (OUT_W-1));

  logic             CLK, reset_n;
  logic             in_valid, in_first, in_last, out_ready;
  logic [LW-1:0]    A, B;
  logic             s_in_ready, s_out_valid, s_out_ovf;
  logic             w_in_ready, w_out_valid, w_out_ovf;
  logic             f_in_ready, f_out_valid, f_out_ovf;
  logic [OUT_W-1:0] s_out_data, w_out_data, f_out_data;

  pe_dot_acc u_dut (
    .CLK(CLK), .reset_n(reset_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_first(in_first), .in_last(in_last), .A(A), .B(B),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_ovf(s_out_ovf)
  );

  pe_dot_acc #(.SAT(1'b0)) u_dut_wrap (
    .CLK(CLK), .reset_n(reset_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_first(in_first), .in_last(in_last), .A(A), .B(B),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data), .out_ovf(w_out_ovf)
  );

  pe_dot_acc #(.FRAC(4)) u_dut_frac (
    .CLK(CLK), .reset_n(reset_n), .in_valid(in_valid), .in_ready(f_in_ready),
    .in_first(in_first), .in_last(in_last), .A(A), .B(B),
    .out_valid(f_out_valid), .out_ready(out_ready), .out_data(f_out_data), .out_ovf(f_out_ovf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    longint sat_d;  bit sat_o;
    longint wrap_d; bit wrap_o;
    longint frac_d; bit frac_o;
  } exp_t;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     n_results = 0;
  exp_t   q[$];
  longint m_acc = 0;
  longint m_dot;
  exp_t   m_e;
  exp_t   m_got;
  bit     rnd_done = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sx(input logic [OUT_W-1:0] d);
    return longint'($signed(d));
  endfunction

  function automatic logic [LW-1:0] pack(input int l0, input int l1, input int l2, input int l3);
    logic [LW-1:0] v;
    int ln[4];
    ln = '{l0, l1, l2, l3};
    v = '0;
    for (int k = 0; k < LANES; k++) v[(LANES-k)*W-1 -: W] = W'(ln[k]);
    return v;
  endfunction

  function automatic longint lane(input logic [LW-1:0] v, input int k);
    return longint'($signed(v[(LANES-k)*W-1 -: W]));
  endfunction

  // Expected output of a finished sequence sum for one configuration.
  function automatic void model_out(input longint acc, input int frac, input bit sat,
                                    output longint d, output bit o);
    longint r;
    r = acc >>> frac;
    o = (r > OMAX) || (r < OMIN);
    if (!o)       d = r;
    else if (sat) d = (r < 0) ? OMIN : OMAX;
    else          d = (r <<< (64-OUT_W)) >>> (64-OUT_W);
  endfunction

  // Scoreboard: accepted beats build sums, handshaked results are checked in order.
  always @(negedge CLK) begin
    if (!reset_n) begin
      q.delete();
      m_acc = 0;
    end else begin
      if (s_out_valid && out_ready) begin
        n_results++;
        if (q.size() == 0) begin
          check("sb_unexpected_result", q.size(), 1);
        end else begin
          m_e = q.pop_front();
          check("sb_sat_data",  sx(s_out_data), m_e.sat_d);
          check("sb_sat_ovf",   s_out_ovf,      m_e.sat_o);
          check("sb_wrap_vld",  w_out_valid,    1);
          check("sb_wrap_data", sx(w_out_data), m_e.wrap_d);
          check("sb_wrap_ovf",  w_out_ovf,      m_e.wrap_o);
          check("sb_frac_vld",  f_out_valid,    1);
          check("sb_frac_data", sx(f_out_data), m_e.frac_d);
          check("sb_frac_ovf",  f_out_ovf,      m_e.frac_o);
        end
      end
      if (in_valid && s_in_ready) begin
        m_dot = 0;
        for (int k = 0; k < LANES; k++) m_dot += lane(A, k) * lane(B, k);
        if (in_first) m_acc = 0;
        m_acc = m_acc + m_dot;
        m_acc = (m_acc <<< (64-ACC_W)) >>> (64-ACC_W);
        if (in_last) begin
          model_out(m_acc, 0, 1'b1, m_e.sat_d,  m_e.sat_o);
          model_out(m_acc, 0, 1'b0, m_e.wrap_d, m_e.wrap_o);
          model_out(m_acc, 4, 1'b1, m_e.frac_d, m_e.frac_o);
          q.push_back(m_e);
          m_acc = 0;
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input logic [LW-1:0] a, input logic [LW-1:0] b,
                           input logic f, input logic l);
    bit ok;
    ok = 0;
    in_valid = 1'b1; A = a; B = b; in_first = f; in_last = l;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge CLK);
      ok = s_in_ready;
    end
    if (!ok) check("send_wait_in_ready", s_in_ready, 1);
    else begin
      check("wrap_in_ready", w_in_ready, 1);
      check("frac_in_ready", f_in_ready, 1);
    end
    @(posedge CLK); #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  // Watches 10 cycles and reports the first result seen and how many valid cycles.
  task automatic collect(output int lat, output int cnt, output exp_t got);
    lat = 0; cnt = 0;
    got = '{0, 0, 0, 0, 0, 0};
    for (int t = 1; t <= 10; t++) begin
      @(posedge CLK); #1;
      if (s_out_valid) begin
        if (cnt == 0) begin
          lat = t;
          got = '{sx(s_out_data), s_out_ovf, sx(w_out_data), w_out_ovf,
                  sx(f_out_data), f_out_ovf};
        end
        cnt++;
      end
    end
  endtask

  function automatic int rnd_lane();
    int sel;
    sel = int'($urandom_range(0, 15));
    if (sel == 0) return int'(OMIN);
    if (sel == 1) return int'(OMAX);
    if (sel < 6)  return int'($urandom_range(0, (1 << W) - 1)) - (1 << (W-1));
    return int'($urandom_range(0, 100)) - 50;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int   lat, cnt, base, stall_seen;
    exp_t got;
    reset_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    A = '0; B = '0; out_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_out_valid", s_out_valid, 0);
    check("rst_out_data",  s_out_data,  0);
    check("rst_out_ovf",   s_out_ovf,   0);
    reset_n = 1'b1;
    #1 check("rst_in_ready", s_in_ready, 1);
    @(posedge CLK); #1;

    // Single beat 1*5+2*6+3*7+4*8.
    send_beat(pack(1, 2, 3, 4), pack(5, 6, 7, 8), 1'b1, 1'b1);
    collect(lat, cnt, got);
    check("single_latency", lat, 4);
    check("single_pulse",   cnt, 1);
    check("single_data",    got.sat_d, 70);
    check("single_ovf",     got.sat_o, 0);

    // Three-beat accumulate: 8 + 12 - 4.
    send_beat(pack(1, 1, 1, 1),     pack(2, 2, 2, 2), 1'b1, 1'b0);
    send_beat(pack(3, 3, 3, 3),     pack(1, 1, 1, 1), 1'b0, 1'b0);
    send_beat(pack(-1, -1, -1, -1), pack(1, 1, 1, 1), 1'b0, 1'b1);
    collect(lat, cnt, got);
    check("acc3_count",   cnt, 1);
    check("acc3_latency", lat, 4);
    check("acc3_data",    got.sat_d, 16);

    // Saturation of 4 * 2^40.
    send_beat(pack(int'(OMIN), int'(OMIN), int'(OMIN), int'(OMIN)),
              pack(int'(OMIN), int'(OMIN), int'(OMIN), int'(OMIN)), 1'b1, 1'b1);
    collect(lat, cnt, got);
    check("sat_data",  got.sat_d, 1048575);
    check("sat_ovf",   got.sat_o, 1);
    check("wrap_data", got.wrap_d, 0);
    check("wrap_ovf",  got.wrap_o, 1);

    // Fixed point: -48 >>> 4.
    send_beat(pack(16, 0, 0, 0), pack(-3, 0, 0, 0), 1'b1, 1'b1);
    collect(lat, cnt, got);
    check("frac_data",    got.frac_d, -3);
    check("frac_ovf",     got.frac_o, 0);
    check("frac0_data",   got.sat_d, -48);

    // Backpressure: out_ready low for 5 cycles while 6 results stream.
    base = n_results;
    stall_seen = 0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send_beat(pack(i+1, i, -i, 2), pack(3, i+2, 1, -i), 1'b1, 1'b1);
      end
      begin
        repeat (2) @(posedge CLK);
        #1 out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge CLK);
          if (s_out_valid) begin
            stall_seen++;
            check("bp_in_ready", s_in_ready, 0);
            if (q.size() > 0) check("bp_hold_data", sx(s_out_data), q[0].sat_d);
          end
          @(posedge CLK); #1;
        end
        out_ready = 1'b1;
      end
    join
    for (int t = 0; t < 30 && q.size() != 0; t++) begin
      @(posedge CLK); #1;
    end
    check("bp_stall_seen", stall_seen > 0, 1);
    check("bp_result_count", n_results - base, 6);
    check("bp_drain", q.size(), 0);

    // Reset in the middle of a three-beat sequence.
    send_beat(pack(7, 7, 7, 7), pack(9, 9, 9, 9), 1'b1, 1'b0);
    send_beat(pack(5, 5, 5, 5), pack(9, 9, 9, 9), 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    check("mrst_out_valid", s_out_valid, 0);
    check("mrst_out_data",  s_out_data,  0);
    check("mrst_out_ovf",   s_out_ovf,   0);
    @(negedge CLK);
    @(posedge CLK); #1;
    reset_n = 1'b1;
    @(posedge CLK); #1;
    send_beat(pack(1, 1, 1, 1), pack(1, 1, 1, 1), 1'b0, 1'b1);
    collect(lat, cnt, got);
    check("mrst_count", cnt, 1);
    check("mrst_data",  got.sat_d, 4);

    // Randomized traffic with random backpressure.
    fork
      begin
        while (!rnd_done) begin
          @(posedge CLK); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 5) == 0) begin
            @(posedge CLK); #1;
          end
          send_beat(pack(rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()),
                    pack(rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
        end
        send_beat(pack(1, 2, 3, 4), pack(4, 3, 2, 1), 1'b0, 1'b1);
        rnd_done = 1;
      end
    join
    out_ready = 1'b1;
    for (int t = 0; t < 50 && q.size() != 0; t++) begin
      @(posedge CLK); #1;
    end
    check("rnd_drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_dot_acc.md
Name: pe_dot_acc

Overview:
- Parametrised successor of the fixed 4-lane, 21-bit dot-product processing element used in the matrix calculator array.
- Computes a signed dot product of two LANES-element vectors per beat through a fully pipelined multiplier and adder tree.
- Optionally accumulates over a multi-beat sequence delimited by first/last flags.
- Emits one fixed-point, optionally saturated result per sequence under a valid/ready handshake with backpressure.

Parameters:
- W, 21, signed element width of each lane of A and B.
- LANES, 4, lanes per beat; power of two, 2..16; LG = log2(LANES).
- ACC_W, 2*W+LG+4, accumulator width; must be ≥ 2*W+LG.
- OUT_W, 21, signed result width.
- FRAC, 0, arithmetic right shift applied to the accumulator before output; 0..ACC_W-1.
- SAT, 1, 1 = clamp to the OUT_W signed range; 0 = truncate (wrap).

Ports:
- CLK, in, 1, rising-edge clock.
- reset_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, beat present on A/B.
- in_ready, out, 1, beat accepted when in_valid && in_ready.
- in_first, in, 1, beat starts a new sequence and discards any prior accumulator value.
- in_last, in, 1, beat ends the sequence; result is produced.
- A, in, LANES*W, lane k at bits [(LANES-k)*W-1 -: W]; lane 0 is the MSB slice.
- B, in, LANES*W, same packing as A.
- out_valid, out, 1, result valid.
- out_ready, in, 1, consumer accepts result.
- out_data, out, OUT_W, result.
- out_ovf, out, 1, result was clamped (SAT=1) or wrapped (SAT=0).

Behaviour:
- Reset (async, reset_n=0): all pipeline valid bits=0, accumulator=0, out_valid=0, out_data=0, out_ovf=0. in_ready reads 1 once reset_n=1. Reset mid-sequence drops all in-flight beats; no partial result is emitted.
- Stall: stall = out_valid && !out_ready. in_ready = !stall. When stall=1 every pipeline register, including valid/first/last sidebands and the accumulator, holds. There are no bubbles to squeeze; the whole pipe freezes.
- Stage M (1 cycle): per-lane signed product a_k*b_k at full 2*W bits, registered with valid/first/last.
- Stages T1..TLG (1 cycle each): binary adder tree. Operands are sign-extended by one bit per level, so no overflow is possible inside the tree.
- Stage C (1 cycle): acc <= (first ? 0 : acc) + sign-extended tree sum, wrapping at ACC_W.
  - If last: form r = acc_new >>> FRAC.
  - SAT=1: clamp r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_ovf = clamped.
  - SAT=0: out_data = r[OUT_W-1:0]; out_ovf = r does not fit in OUT_W.
  - Load out_data, out_ovf, out_valid=1.
  - After a last beat the accumulator is logically cleared; the next beat behaves as first even if in_first=0.
- Latency: last beat accepted at edge n → out_valid=1 after edge n+LG+2 (LANES=4: 4 cycles). Throughput is 1 beat/cycle with no stalls.
- Output register: out_valid clears on edge where out_ready=1 unless a new last-beat result loads on the same edge, in which case out_valid stays 1 with the new data. While out_valid && out_ready, the pipe advances, so back-to-back single-beat sequences stream at 1/cycle.
- out_valid/out_data/out_ovf are stable while out_valid && !out_ready.
- in_first && in_last in the same beat is a single-beat dot product.
- A beat arriving while the accumulator is idle with in_first=0 starts a new sequence, implicitly as first.
- Inputs are ignored when in_valid=0 or in_ready=0; sideband flags are sampled only on acceptance.

Test Plan (W=21, LANES=4, OUT_W=21, FRAC=0, SAT=1 unless noted):
- Single beat: A={1,2,3,4}, B={5,6,7,8}, first=last=1, out_ready=1 → out_valid=1 exactly 4 cycles after acceptance, out_data=70, out_ovf=0; pulse width 1.
- Three-beat accumulate: beats of all-lanes {1,1,1,1}·{2,2,2,2}, {3,…}·{1,…}, {-1,…}·{1,…} with first on beat 0, last on beat 2 → single result 8+12-4=16; no intermediate out_valid.
- Saturation: all lanes A=B=-2^20, single beat → raw sum 2^42; out_data=1048575 (0x0FFFFF), out_ovf=1. Repeat with SAT=0 → out_data=0, out_ovf=1.
- Backpressure: stream 6 single-beat sequences with out_ready held 0 from cycle 2 for 5 cycles → in_ready=0 during stall, out_data frozen. On release, all 6 results arrive in order with none lost or duplicated.
- Fixed point: FRAC=4, single beat A={16,0,0,0}, B={-3,0,0,0} → out_data=-3 (arithmetic shift of -48), out_ovf=0.
- Async reset mid-sequence: assert reset_n=0 between beats 1 and 2 of a 3-beat sequence → outputs 0 immediately. After release, a new single-beat {1,1,1,1}·{1,1,1,1} with first=0 yields 4 (no stale accumulation).
